step_controller: RTL and testbench

Single-step / run clock-enable controller for the FPGA build of the MIPS core. It consumes two already-debounced push-button levels (step and mode) and produces a registered `cpu_en` qualifier for the processor's state elements. It supports three behaviours: one pulse per step press, auto-repeat while the step button is held, and a free-running mode with programmable rate. It also keeps a wrap-around count of issued enables for display on the board.

---
 rtl/step_controller_if.sv | 27 ++
 rtl/step_controller.sv | 138 +++++++++++++
 tb/tb_step_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_controller_if.sv
// Button, halt and enable signals shared by the step controller and the board logic that drives it.
interface step_controller_if;
  logic        step_btn;
  logic        mode_btn;
  logic        cpu_halt;
  logic        cpu_en;
  logic        run_mode;
  logic [15:0] step_count;

  modport master (
    output step_btn,
    output mode_btn,
    output cpu_halt,
    input  cpu_en,
    input  run_mode,
    input  step_count
  );

  modport slave (
    input  step_btn,
    input  mode_btn,
    input  cpu_halt,
    output cpu_en,
    output run_mode,
    output step_count
  );
endinterface

// File: rtl/step_controller.sv
// Single-step / auto-repeat / free-run clock-enable controller for the MIPS core.
// It also counts issued enables for the board display.
module step_controller #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned RUN_DIV       = 1,
  parameter int unsigned CNT_W         = 26
) (
  input  logic             clk,
  input  logic             reset,
  step_controller_if.slave bus
);

  localparam int unsigned COUNT_W = 16;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic               step_prev_q, mode_prev_q;
  logic               run_mode_q, run_mode_d;
  logic               cpu_en_q, cpu_en_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic step_rise_c;
  logic mode_rise_c;
  logic mode_chg_c;
  logic pulse_c;

  // State register and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      presc_q     <= '0;
      step_prev_q <= 1'b0;
      mode_prev_q <= 1'b0;
      run_mode_q  <= 1'b0;
      cpu_en_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      presc_q     <= presc_d;
      step_prev_q <= bus.step_btn;
      mode_prev_q <= bus.mode_btn;
      run_mode_q  <= run_mode_d;
      cpu_en_q    <= cpu_en_d;
      count_q     <= count_d;
    end
  end

  // Mode selection, step FSM, run prescaler and halt gating
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    presc_d    = presc_q;
    run_mode_d = run_mode_q;
    pulse_c    = 1'b0;

    step_rise_c = bus.step_btn & ~step_prev_q;
    mode_rise_c = bus.mode_btn & ~mode_prev_q;

    if (bus.cpu_halt) begin
      run_mode_d = 1'b0;
    end else if (mode_rise_c) begin
      run_mode_d = ~run_mode_q;
    end
    // Any mode change (toggle or halt-forced exit) restarts from a clean IDLE.
    mode_chg_c = (run_mode_d != run_mode_q);

    if (mode_chg_c) begin
      state_d = S_IDLE;
      timer_d = '0;
      presc_d = '0;
    end else if (run_mode_q) begin
      state_d = S_IDLE;
      if (presc_q == RUN_LAST) begin
        pulse_c = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_rise_c) begin
            pulse_c = 1'b1;
            timer_d = '0;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!bus.step_btn) begin
            state_d = S_IDLE;
          end else if (timer_q == HOLD_LAST) begin
            pulse_c = 1'b1;
            timer_d = '0;
            state_d = S_REPEAT;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!bus.step_btn) begin
            state_d = S_IDLE;
          end else if (timer_q == REPEAT_LAST) begin
            pulse_c = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end

    // Pulses requested while halted are dropped, never queued.
    cpu_en_d = pulse_c & ~bus.cpu_halt;
    count_d  = count_q + COUNT_W'(cpu_en_d);
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.run_mode   = run_mode_q;
  assign bus.step_count = count_q;

endmodule

// File: tb/tb_step_controller.sv
// Scoreboard bench for step_controller: two instances (RUN_DIV=3 and RUN_DIV=1), HOLD=10, REPEAT=4.
module tb_step_controller;

  typedef struct packed {
    logic        en;
    logic        rm;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  step_controller_if bus_a ();
  step_controller_if bus_b ();

  step_controller #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .RUN_DIV      (3),
    .CNT_W        (8)
  ) dut_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (bus_a)
  );

  step_controller #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .RUN_DIV      (1),
    .CNT_W        (8)
  ) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (bus_b)
  );

  exp_t        sb_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        rm_a, rm_b;
  logic [15:0] cnt_a, cnt_b;

  task automatic push_a(input logic en);
    exp_t x;
    if (en) cnt_a = cnt_a + 16'd1;
    x.en = en; x.rm = rm_a; x.cnt = cnt_a;
    sb_q.push_back(x);
  endtask

  task automatic push_b(input logic en);
    exp_t x;
    if (en) cnt_b = cnt_b + 16'd1;
    x.en = en; x.rm = rm_b; x.cnt = cnt_b;
    sb_q.push_back(x);
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_a: got en=%b rm=%b cnt=%0d, want 0/0/0", bus_a.cpu_en, bus_a.run_mode, bus_a.step_count);
    end
    n_checks++;
    if ({bus_b.cpu_en, bus_b.run_mode, bus_b.step_count} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_b: got en=%b rm=%b cnt=%0d, want 0/0/0", bus_b.cpu_en, bus_b.run_mode, bus_b.step_count);
    end
    rm_a = 1'b0; rm_b = 1'b0; cnt_a = 16'd0; cnt_b = 16'd0;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_single_press;
    for (int i = 0; i < 9; i++) begin
      bus_a.step_btn = (i >= 2 && i <= 4);
      push_a(i == 2);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== e) begin
        n_errors++;
        $display("FAIL single_press cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_a.cpu_en, bus_a.run_mode, bus_a.step_count, e.en, e.rm, e.cnt);
      end
    end
  endtask

  task automatic test_auto_repeat;
    for (int i = 0; i < 37; i++) begin
      bus_a.step_btn = (i <= 30);
      push_a((i == 0) || (i >= 10 && i <= 30 && ((i - 10) % 4) == 0));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== e) begin
        n_errors++;
        $display("FAIL auto_repeat cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_a.cpu_en, bus_a.run_mode, bus_a.step_count, e.en, e.rm, e.cnt);
      end
    end
    n_checks++;
    if (bus_a.step_count !== 16'd8) begin
      n_errors++;
      $display("FAIL auto_repeat_total: got cnt=%0d, want 8", bus_a.step_count);
    end
  endtask

  task automatic test_run_mode;
    for (int i = 0; i < 19; i++) begin
      bus_a.mode_btn = (i == 0 || i == 14);
      bus_a.step_btn = (i >= 1 && i <= 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 0) rm_a = 1'b1;
      if (i == 14) rm_a = 1'b0;
      push_a(i >= 1 && i <= 13 && (i % 3) == 0);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== e) begin
        n_errors++;
        $display("FAIL run_mode cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_a.cpu_en, bus_a.run_mode, bus_a.step_count, e.en, e.rm, e.cnt);
      end
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 8; i++) begin
      bus_a.step_btn = (i <= 3);
      bus_a.mode_btn = (i == 0 || i == 4);
      if (i == 0) rm_a = 1'b1;
      if (i == 4) rm_a = 1'b0;
      push_a(i == 3);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== e) begin
        n_errors++;
        $display("FAIL simultaneous cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_a.cpu_en, bus_a.run_mode, bus_a.step_count, e.en, e.rm, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    for (int i = 0; i < 5; i++) begin
      bus_a.step_btn = 1'b1;
      push_a(i == 0);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== e) begin
        n_errors++;
        $display("FAIL pre_reset cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_a.cpu_en, bus_a.run_mode, bus_a.step_count, e.en, e.rm, e.cnt);
      end
    end
    #2 rst_a = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== 18'd0) begin
      n_errors++;
      $display("FAIL async_reset: got en=%b rm=%b cnt=%0d, want 0/0/0", bus_a.cpu_en, bus_a.run_mode, bus_a.step_count);
    end
    rm_a = 1'b0; cnt_a = 16'd0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== 18'd0) begin
      n_errors++;
      $display("FAIL held_reset: got en=%b rm=%b cnt=%0d, want 0/0/0", bus_a.cpu_en, bus_a.run_mode, bus_a.step_count);
    end
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_a.step_btn = (i <= 4);
      push_a(i == 0);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_a.cpu_en, bus_a.run_mode, bus_a.step_count} !== e) begin
        n_errors++;
        $display("FAIL post_reset cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_a.cpu_en, bus_a.run_mode, bus_a.step_count, e.en, e.rm, e.cnt);
      end
    end
  endtask

  task automatic test_halt;
    for (int i = 0; i < 14; i++) begin
      bus_b.mode_btn = (i == 0 || i == 7);
      bus_b.cpu_halt = (i >= 5 && i <= 9);
      bus_b.step_btn = ((i >= 6 && i <= 8) || i == 11);
      if (i == 0) rm_b = 1'b1;
      if (i == 5) rm_b = 1'b0;
      push_b((i >= 1 && i <= 4) || i == 11);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_b.cpu_en, bus_b.run_mode, bus_b.step_count} !== e) begin
        n_errors++;
        $display("FAIL halt cyc %0d: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
                 i, bus_b.cpu_en, bus_b.run_mode, bus_b.step_count, e.en, e.rm, e.cnt);
      end
    end
  endtask

  task automatic test_wrap;
    int n;
    bus_b.mode_btn = 1'b1;
    rm_b = 1'b1;
    push_b(1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++;
    if ({bus_b.cpu_en, bus_b.run_mode, bus_b.step_count} !== e) begin
      n_errors++;
      $display("FAIL wrap_enter: got en=%b rm=%b cnt=%0d, want en=%b rm=%b cnt=%0d",
               bus_b.cpu_en, bus_b.run_mode, bus_b.step_count, e.en, e.rm, e.cnt);
    end
    bus_b.mode_btn = 1'b0;
    n = 65535 - int'(cnt_b);
    repeat (n - 1) @(posedge clk);
    #1;
    cnt_b = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      bus_b.mode_btn = (i == 2);
      if (i == 2) rm_b = 1'b0;
      push_b(i < 2);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({bus_b.cpu_en, bus_b.run_mode, bus_b.step_count} !== e) begin
        n_errors++;
        $display("FAIL wrap cyc %0d: got en=%b rm=%b cnt=%h, want en=%b rm=%b cnt=%h",
                 i, bus_b.cpu_en, bus_b.run_mode, bus_b.step_count, e.en, e.rm, e.cnt);
      end
    end
    bus_b.mode_btn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus_a.step_btn = 1'b0; bus_a.mode_btn = 1'b0; bus_a.cpu_halt = 1'b0;
    bus_b.step_btn = 1'b0; bus_b.mode_btn = 1'b0; bus_b.cpu_halt = 1'b0;
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_run_mode();
    test_simultaneous();
    test_reset_mid_hold();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
